lock_key_loader: RTL and testbench

Serial key transmitter for latch-locked benchmark cores. It captures a KEY_WIDTH-bit unlock key from the on-chip key store and shifts it LSB-first into the locked core's key register with a shift-enable strobe, then issues a one-cycle update pulse. It holds the locked core in reset (`core_rst`) until the key is fully delivered, which makes it the transmit end of the key-chain interface that every locked core receives on.

---
 rtl/lock_key_loader_if.sv | 32 +++
 rtl/lock_key_loader.sv | 112 +++++++++++
 tb/tb_lock_key_loader.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lock_key_loader_if.sv
// Key-chain bus between a key loader and its controller.
//   start, abort : load request / cancel from the controller
//   key_in       : KEY_WIDTH-bit key word, captured when start is accepted
//   key_sdata    : serial key bit toward the locked core (LSB first)
//   key_sen      : shift strobe, core shifts key_sdata on edges where this is 1
//   key_upd      : one-cycle pulse, core commits its shift register
//   core_rst     : active-high reset held on the locked core until delivery
//   busy, done   : load in progress / key delivered
// The controller side uses the master modport; the loader uses slave.
interface lock_key_loader_if #(
  parameter int KEY_WIDTH = 16
) ();
  logic                 start;
  logic                 abort;
  logic [KEY_WIDTH-1:0] key_in;
  logic                 key_sdata;
  logic                 key_sen;
  logic                 key_upd;
  logic                 core_rst;
  logic                 busy;
  logic                 done;

  modport master (
    output start, abort, key_in,
    input  key_sdata, key_sen, key_upd, core_rst, busy, done
  );

  modport slave (
    input  start, abort, key_in,
    output key_sdata, key_sen, key_upd, core_rst, busy, done
  );
endinterface

// File: rtl/lock_key_loader.sv
// Serial key transmitter for latch-locked cores.
// Captures a KEY_WIDTH-bit key, shifts it LSB first into the locked core's key
// register with one strobe every DIV cycles, issues a one-cycle update pulse,
// and keeps the core in reset until the whole key has been delivered.
// Ports:
//   clk : single clock, rising edge
//   rst : asynchronous active-low reset
//   bus : lock_key_loader_if.slave (start/abort/key_in in; key_sdata, key_sen,
//         key_upd, core_rst, busy, done out)
// Every output is decoded from state, counters and the shadow key only, so
// there is no combinational path from any input to any output.
module lock_key_loader #(
  parameter int KEY_WIDTH = 16,
  parameter int DIV       = 2
) (
  input  logic                clk,
  input  logic                rst,
  lock_key_loader_if.slave    bus
);

  localparam int BW = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(KEY_WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [KEY_WIDTH-1:0] shadow;
  logic [BW-1:0]        bit_cnt;
  logic [DW-1:0]        div_cnt;
  logic                 accept;
  logic                 strobe;
  logic                 last_bit;

  // Next-state decode. abort has priority over everything, including a
  // start that arrives in the same cycle.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    strobe     = (state == SHIFT) && (div_cnt == DIV_LAST);
    last_bit   = (bit_cnt == BIT_LAST);
    if (bus.abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            accept     = 1'b1;
            state_next = SHIFT;
          end
        end
        SHIFT: begin
          if (strobe && last_bit) begin
            state_next = UPDATE;
          end
        end
        UPDATE: begin
          state_next = DONE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Shadow key and counters. The key is frozen at accept time so later
  // key_in changes cannot corrupt a load. bit_cnt wrapping on the last strobe
  // is harmless because the state leaves SHIFT on that same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow  <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (accept) begin
      shadow  <= bus.key_in;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (state == SHIFT && !bus.abort) begin
      if (strobe) begin
        div_cnt <= '0;
        bit_cnt <= bit_cnt + BW'(1);
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  // Output decode; the core stays in reset in every state except DONE.
  assign bus.key_sdata = (state == SHIFT) ? shadow[bit_cnt] : 1'b0;
  assign bus.key_sen   = strobe;
  assign bus.key_upd   = (state == UPDATE);
  assign bus.core_rst  = (state != DONE);
  assign bus.busy      = (state == SHIFT) || (state == UPDATE);
  assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_lock_key_loader.sv
// Bench for lock_key_loader: two instances (16-bit key / DIV=2 and
// 8-bit key / DIV=1) driven by one stimulus process. Each issued load pushes
// its expected strobes, update pulse and status snapshots into queues; a
// separate monitor pops and compares whenever the loaders present outputs.
module tb_lock_key_loader;
  localparam int KW0 = 16;
  localparam int DV0 = 2;
  localparam int KW1 = 8;
  localparam int DV1 = 1;
  localparam int T0  = KW0 * DV0 + 2;
  localparam int T1  = KW1 * DV1 + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lock_key_loader_if #(.KEY_WIDTH(KW0)) bus0 ();
  lock_key_loader_if #(.KEY_WIDTH(KW1)) bus1 ();

  lock_key_loader #(.KEY_WIDTH(KW0), .DIV(DV0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  lock_key_loader #(.KEY_WIDTH(KW1), .DIV(DV1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    bit upd;
    bit sdata;
    int cyc;
  } ev_t;

  typedef struct {
    int u;
    int cyc;
    bit busy;
    bit done;
    bit core_rst;
  } st_t;

  ev_t q0[$];
  ev_t q1[$];
  st_t stq[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  bit  end_req  = 1'b0;
  bit  end_ack  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic void push_ev(int u, bit upd, bit sdata, int c);
    ev_t e;
    e.upd = upd; e.sdata = sdata; e.cyc = c;
    if (u == 0) q0.push_back(e); else q1.push_back(e);
  endfunction

  function automatic void push_st(int u, int c, bit busy, bit done, bit crst);
    st_t s;
    s.u = u; s.cyc = c; s.busy = busy; s.done = done; s.core_rst = crst;
    stq.push_back(s);
  endfunction

  function automatic void push_idle(int u, int c);
    push_st(u, c, 1'b0, 1'b0, 1'b1);
  endfunction

  // c0 is the cycle before the first SHIFT cycle; bit i is strobed in cycle
  // c0+(i+1)*DIV, update follows, then the core is released.
  function automatic void push_load(int u, logic [15:0] key, int c0);
    int kw = (u == 0) ? KW0 : KW1;
    int dv = (u == 0) ? DV0 : DV1;
    for (int i = 0; i < kw; i++) push_ev(u, 1'b0, key[i], c0 + (i + 1) * dv);
    push_ev(u, 1'b1, 1'b0, c0 + kw * dv + 1);
    push_st(u, c0 + 1, 1'b1, 1'b0, 1'b1);
    push_st(u, c0 + kw * dv + 1, 1'b1, 1'b0, 1'b1);
    push_st(u, c0 + kw * dv + 2, 1'b0, 1'b1, 1'b0);
  endfunction

  // Drop every expectation of unit u from cycle 'from' onward.
  function automatic void cancel(int u, int from);
    ev_t k[$];
    st_t ks[$];
    if (u == 0) begin
      foreach (q0[i]) if (q0[i].cyc < from) k.push_back(q0[i]);
      q0 = k;
    end else begin
      foreach (q1[i]) if (q1[i].cyc < from) k.push_back(q1[i]);
      q1 = k;
    end
    foreach (stq[i]) if (!(stq[i].u == u && stq[i].cyc >= from)) ks.push_back(stq[i]);
    stq = ks;
  endfunction

  // ---------------- monitor ----------------
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_unit(int u, logic sen, logic upd, logic sd);
    ev_t e;
    check($sformatf("u%0d_sen_upd_excl", u), 32'(sen === 1'b1 && upd === 1'b1), 32'd0);
    if (sen === 1'b1 || upd === 1'b1) begin
      if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
        checks++;
        failures++;
        $display("FAIL u%0d_unexpected_output: got sen=%0b upd=%0b expected none (cycle %0d)",
                 u, sen, upd, cyc);
      end else begin
        e = (u == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("u%0d_kind_upd", u), 32'(upd), 32'(e.upd));
        check($sformatf("u%0d_event_cycle", u), cyc, e.cyc);
        if (!e.upd) check($sformatf("u%0d_sdata", u), 32'(sd), 32'(e.sdata));
      end
    end
  endtask

  task automatic mon_status(st_t s);
    logic b, d, r, sd;
    b  = (s.u == 0) ? bus0.busy      : bus1.busy;
    d  = (s.u == 0) ? bus0.done      : bus1.done;
    r  = (s.u == 0) ? bus0.core_rst  : bus1.core_rst;
    sd = (s.u == 0) ? bus0.key_sdata : bus1.key_sdata;
    check($sformatf("u%0d_busy", s.u), 32'(b), 32'(s.busy));
    check($sformatf("u%0d_done", s.u), 32'(d), 32'(s.done));
    check($sformatf("u%0d_core_rst", s.u), 32'(r), 32'(s.core_rst));
    if (!s.busy) check($sformatf("u%0d_sdata_idle", s.u), 32'(sd), 32'd0);
  endtask

  initial begin
    st_t keep[$];
    forever begin
      @(negedge clk);
      mon_unit(0, bus0.key_sen, bus0.key_upd, bus0.key_sdata);
      mon_unit(1, bus1.key_sen, bus1.key_upd, bus1.key_sdata);
      keep.delete();
      foreach (stq[i]) begin
        if (stq[i].cyc == cyc) mon_status(stq[i]);
        else if (stq[i].cyc < cyc) check("status_missed", stq[i].cyc, cyc);
        else keep.push_back(stq[i]);
      end
      stq = keep;
      if (end_req && !end_ack) begin
        check("u0_events_left", q0.size(), 0);
        check("u1_events_left", q1.size(), 0);
        check("status_left", stq.size(), 0);
        end_ack = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(int n);
    repeat (n) tick();
  endtask

  task automatic start_load(bit s0, bit s1, logic [15:0] k0, logic [7:0] k1, output int c0);
    bus0.start = s0;
    bus1.start = s1;
    if (s0) bus0.key_in = k0;
    if (s1) bus1.key_in = k1;
    tick();
    c0 = cyc - 1;
    if (s0) push_load(0, k0, c0);
    if (s1) push_load(1, {8'h00, k1}, c0);
    bus0.start  = 1'b0;
    bus1.start  = 1'b0;
    bus0.key_in = 16'($urandom);
    bus1.key_in = 8'($urandom);
  endtask

  task automatic abort_both();
    int a;
    bus0.abort = 1'b1;
    bus1.abort = 1'b1;
    tick();
    a = cyc;
    cancel(0, a);
    cancel(1, a);
    push_idle(0, a);
    push_idle(1, a);
    bus0.abort = 1'b0;
    bus1.abort = 1'b0;
  endtask

  initial begin
    int c;
    int c2;
    logic [15:0] k2;
    bus0.start = 1'b0; bus0.abort = 1'b0; bus0.key_in = '0;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.key_in = '0;

    // reset state
    wait_cycles(2);
    push_idle(0, cyc);
    push_idle(1, cyc);
    tick();
    rst = 1'b1;
    wait_cycles(2);

    // default load; key_in changes right after capture
    start_load(1'b1, 1'b1, 16'hA5C3, 8'h81, c);
    bus0.key_in = 16'h0000;
    bus1.key_in = 8'h00;
    wait_cycles(T0 + 2);

    // abort during cycle 10 (unit1 is already in DONE then)
    start_load(1'b1, 1'b1, 16'($urandom), 8'($urandom), c);
    wait_cycles(9);
    abort_both();
    push_idle(0, cyc + 3);
    push_idle(1, cyc + 3);
    wait_cycles(4);

    // abort and start together in IDLE: nothing happens
    bus0.abort = 1'b1; bus1.abort = 1'b1;
    bus0.start = 1'b1; bus1.start = 1'b1;
    tick();
    push_idle(0, cyc);
    push_idle(1, cyc);
    push_idle(0, cyc + 2);
    push_idle(1, cyc + 2);
    bus0.abort = 1'b0; bus1.abort = 1'b0;
    bus0.start = 1'b0; bus1.start = 1'b0;
    wait_cycles(3);

    // reload straight from DONE
    start_load(1'b1, 1'b1, 16'h0001, 8'h01, c);
    wait_cycles(T0);
    start_load(1'b1, 1'b1, 16'hFFFF, 8'hFF, c2);
    wait_cycles(T0 + 2);

    // asynchronous reset in the middle of cycle 7
    start_load(1'b1, 1'b1, 16'($urandom), 8'($urandom), c);
    wait_cycles(6);
    #2;
    rst = 1'b0;
    cancel(0, c + 7);
    cancel(1, c + 7);
    push_idle(0, c + 7); push_idle(1, c + 7);
    push_idle(0, c + 8); push_idle(1, c + 8);
    wait_cycles(2);
    rst = 1'b1;
    push_idle(0, cyc + 1);
    push_idle(1, cyc + 1);
    wait_cycles(3);

    // start held high across a whole load on unit0: one load, then retrigger
    k2 = 16'($urandom);
    bus0.key_in = 16'($urandom);
    bus0.start  = 1'b1;
    tick();
    c = cyc - 1;
    push_load(0, bus0.key_in, c);
    bus0.key_in = k2;
    push_load(0, k2, c + T0);
    wait_cycles(T0);
    bus0.start = 1'b0;
    wait_cycles(T0 + 2);

    // randomized loads, some aborted, some reloaded straight from DONE
    for (int it = 0; it < 10; it++) begin
      start_load(1'b1, ($urandom % 4) != 0, 16'($urandom), 8'($urandom), c);
      if ($urandom % 2) begin
        wait_cycles(int'($urandom_range(0, T0 - 1)));
        abort_both();
        wait_cycles(2);
      end else begin
        wait_cycles(T0 + int'($urandom_range(0, 3)));
      end
    end
    if (T1 > T0) $display("note: unit1 period exceeds unit0 period");

    wait_cycles(3);
    end_req = 1'b1;
    repeat (5) if (!end_ack) tick();
    if (!end_ack) begin
      $display("FAIL end_handshake: got no monitor acknowledge expected acknowledge");
      $fatal(1, "monitor did not respond");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
